// File: rtl/td4_pkg.sv
// Shared types and sizing for the TD4 execution controller and its program memory.
package td4_pkg;

  localparam int unsigned OpW      = 4;
  localparam int unsigned ImmW     = 4;
  localparam int unsigned InstrW   = OpW + ImmW;
  localparam int unsigned MemDepth = 16;
  localparam int unsigned AddrW    = $clog2(MemDepth);
  localparam int unsigned DivW     = 8;
  localparam int unsigned CountW   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStep,
    StHalt
  } state_e;

  function automatic logic [OpW-1:0] instr_opcode(input logic [InstrW-1:0] instr);
    return instr[InstrW-1 -: OpW];
  endfunction

  function automatic logic [ImmW-1:0] instr_imm(input logic [InstrW-1:0] instr);
    return instr[ImmW-1:0];
  endfunction

endpackage

// File: rtl/td4_prog_mem.sv
// 16x8 instruction store: synchronous write, asynchronous read, never reset so a
// loaded program survives a controller reset.
module td4_prog_mem
  import td4_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AddrW-1:0]  waddr_i,
  input  logic [InstrW-1:0] wdata_i,
  input  logic [AddrW-1:0]  raddr_i,
  output logic [InstrW-1:0] rdata_o
);

  logic [InstrW-1:0] mem_q [MemDepth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/td4_exec_ctrl.sv
// Run/step/halt sequencer for a TD4 core: paces instruction issue with a clock divider,
// handles a single PC breakpoint and guards program-memory writes while executing.
module td4_exec_ctrl
  import td4_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [AddrW-1:0]  prog_addr,
  input  logic [InstrW-1:0] prog_data,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic              bp_en,
  input  logic [AddrW-1:0]  bp_addr,
  input  logic [AddrW-1:0]  cpu_pc,
  output logic [OpW-1:0]    opcode,
  output logic [ImmW-1:0]   immediate,
  output logic              exec_mode,
  output logic              running,
  output logic              halted,
  output logic              bp_hit,
  output logic              wr_err,
  output logic [CountW-1:0] exec_count
);

  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              exec_q, exec_d;
  logic [CountW-1:0] count_q, count_d;
  logic              bp_hit_q, bp_hit_d;
  logic              wr_err_q, wr_err_d;
  logic              skip_bp_q, skip_bp_d;
  logic              mem_we;
  logic              bp_match;
  logic [InstrW-1:0] instr;

  // Writes are only safe while nothing is being fetched for execution.
  assign mem_we   = prog_we && ((state_q == StIdle) || (state_q == StHalt));
  assign bp_match = bp_en && (cpu_pc == bp_addr) && !skip_bp_q;

  td4_prog_mem u_prog_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (cpu_pc),
    .rdata_o (instr)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    exec_d    = 1'b0;
    bp_hit_d  = bp_hit_q;
    wr_err_d  = wr_err_q;
    skip_bp_d = skip_bp_q;
    count_d   = count_q + CountW'(exec_q);

    if (prog_we && !mem_we) begin
      wr_err_d = 1'b1;
    end

    unique case (state_q)
      StIdle, StHalt: begin
        if (cmd_halt) begin
          state_d = StHalt;
        end else if (cmd_step) begin
          state_d   = StStep;
          bp_hit_d  = 1'b0;
          wr_err_d  = 1'b0;
          skip_bp_d = (state_q == StHalt);
        end else if (cmd_run) begin
          state_d   = StRun;
          div_d     = '0;
          bp_hit_d  = 1'b0;
          wr_err_d  = 1'b0;
          skip_bp_d = (state_q == StHalt);
        end
      end
      StRun: begin
        if (cmd_halt) begin
          state_d = StHalt;
          div_d   = '0;
        end else if (div_q == DivMax) begin
          div_d = '0;
          if (bp_match) begin
            state_d  = StHalt;
            bp_hit_d = 1'b1;
          end else begin
            exec_d    = 1'b1;
            skip_bp_d = 1'b0;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StStep: begin
        // A single step always executes; the breakpoint is not consulted here.
        exec_d    = 1'b1;
        skip_bp_d = 1'b0;
        state_d   = StHalt;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      exec_q    <= 1'b0;
      count_q   <= '0;
      bp_hit_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      skip_bp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      exec_q    <= exec_d;
      count_q   <= count_d;
      bp_hit_q  <= bp_hit_d;
      wr_err_q  <= wr_err_d;
      skip_bp_q <= skip_bp_d;
    end
  end

  assign opcode     = instr_opcode(instr);
  assign immediate  = instr_imm(instr);
  assign exec_mode  = exec_q;
  assign running    = (state_q == StRun);
  assign halted     = (state_q == StHalt);
  assign bp_hit     = bp_hit_q;
  assign wr_err     = wr_err_q;
  assign exec_count = count_q;

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// Directed bench for td4_exec_ctrl: step, paced run, breakpoint resume, write guard,
// counter wrap and asynchronous reset.
module tb_td4_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       cmd_run, cmd_step, cmd_halt;
  logic       bp_en;
  logic [3:0] bp_addr;
  logic [3:0] cpu_pc;
  logic [3:0] opcode, immediate;
  logic       exec_mode, running, halted, bp_hit, wr_err;
  logic [7:0] exec_count;

  int checks   = 0;
  int failures = 0;

  td4_exec_ctrl #(.CLK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .cmd_run    (cmd_run),
    .cmd_step   (cmd_step),
    .cmd_halt   (cmd_halt),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .cpu_pc     (cpu_pc),
    .opcode     (opcode),
    .immediate  (immediate),
    .exec_mode  (exec_mode),
    .running    (running),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .wr_err     (wr_err),
    .exec_count (exec_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] vec;
  int          pulses;
  logic        found;

  initial begin
    rst = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    bp_en = 1'b0; bp_addr = '0; cpu_pc = '0;
    cyc(); cyc();
    check_eq("rst_exec", 32'(exec_mode), 0);
    check_eq("rst_count", 32'(exec_count), 0);
    check_eq("rst_flags", {28'd0, running, halted, bp_hit, wr_err}, 0);
    rst = 1'b0;
    cyc();

    // IDLE + halt -> HALT
    cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
    check_eq("idle_halt", 32'(halted), 1);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = (i == 0) ? 8'h31 : (i == 1) ? 8'hF0 : {a, ~a};
      cyc();
    end
    prog_we = 1'b0;
    check_eq("load_wr_err", 32'(wr_err), 0);

    cpu_pc = 4'd0; #1;
    check_eq("fetch0", {24'd0, opcode, immediate}, 32'h31);
    cpu_pc = 4'd1; #1;
    check_eq("fetch1", {24'd0, opcode, immediate}, 32'hF0);
    cpu_pc = 4'd0;

    // Single step
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
    check_eq("step_entry", {29'd0, exec_mode, running, halted}, 0);
    cyc();
    check_eq("step_exec", {30'd0, exec_mode, halted}, 32'b11);
    cyc();
    check_eq("step_done", {23'd0, exec_mode, exec_count}, 1);

    // Paced run: pulses at cycles 5, 9, 13 after the run pulse
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    vec = '0;
    for (int c = 1; c <= 14; c++) begin
      vec[c] = exec_mode;
      cyc();
    end
    check_eq("run_pulses", 32'(vec), 32'h2220);
    check_eq("run_running", 32'(running), 1);
    check_eq("run_count", 32'(exec_count), 4);
    cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
    vec = '0;
    for (int c = 0; c < 6; c++) begin
      vec[c] = exec_mode;
      cyc();
    end
    check_eq("halt_quiet", 32'(vec), 0);
    check_eq("halt_state", {30'd0, running, halted}, 32'b01);
    check_eq("halt_count", 32'(exec_count), 4);

    // Breakpoint at pc 5; first tick after leaving HALT skips the compare
    bp_en = 1'b1; bp_addr = 4'd5; cpu_pc = 4'd3;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    pulses = 0;
    for (int n = 0; n < 60 && !halted; n++) begin
      if (exec_mode) begin
        pulses++;
        cpu_pc = cpu_pc + 4'd1;
      end
      cyc();
    end
    check_eq("bp_pulses", 32'(pulses), 2);
    check_eq("bp_pc", 32'(cpu_pc), 5);
    check_eq("bp_state", {29'd0, exec_mode, halted, bp_hit}, 32'b011);
    check_eq("bp_count", 32'(exec_count), 6);

    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    check_eq("resume_flags", {30'd0, running, bp_hit}, 32'b10);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (exec_mode) found = 1'b1;
      else cyc();
    end
    check_eq("resume_exec", 32'(found), 1);
    check_eq("resume_pc", 32'(cpu_pc), 5);
    cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
    cyc();
    check_eq("resume_count", {23'd0, halted, exec_count}, 32'h107);

    // Step while sitting on the breakpoint PC
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
    cyc();
    check_eq("bp_step_exec", 32'(exec_mode), 1);
    cyc();
    check_eq("bp_step_done", {22'd0, halted, bp_hit, exec_count}, 32'h208);

    // Dropped write during RUN, then halt+run together
    bp_en = 1'b0;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'hAA;
    cyc();
    prog_we = 1'b0;
    check_eq("wr_err_set", 32'(wr_err), 1);
    cmd_halt = 1'b1; cmd_run = 1'b1; cyc(); cmd_halt = 1'b0; cmd_run = 1'b0;
    check_eq("halt_prio", {30'd0, running, halted}, 32'b01);
    cyc();
    check_eq("halt_prio_quiet", 32'(exec_mode), 0);
    cpu_pc = 4'd2; #1;
    check_eq("mem2_kept", {24'd0, opcode, immediate}, 32'h2D);
    check_eq("wr_err_sticky", {23'd0, wr_err, exec_count}, 32'h108);
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
    check_eq("wr_err_clr", 32'(wr_err), 0);
    cyc(); cyc();

    // Reset in HALT keeps the program
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    cpu_pc = 4'd0; #1;
    check_eq("rst_halt_state", {22'd0, halted, running, exec_count}, 0);
    check_eq("rst_mem0", {24'd0, opcode, immediate}, 32'h31);

    // Counter wrap
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    pulses = 0;
    for (int n = 0; n < 1200 && pulses < 255; n++) begin
      if (exec_mode) pulses++;
      cyc();
    end
    check_eq("cnt_255", 32'(exec_count), 255);
    for (int n = 0; n < 20 && pulses < 256; n++) begin
      if (exec_mode) pulses++;
      cyc();
    end
    check_eq("cnt_wrap", 32'(exec_count), 0);

    // Asynchronous reset while an issue is in flight
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (exec_mode) found = 1'b1;
      else cyc();
    end
    check_eq("pre_rst_exec", 32'(found), 1);
    rst = 1'b1; #1;
    check_eq("async_rst", {29'd0, exec_mode, running, halted}, 0);
    #3 rst = 1'b0;
    cyc();
    vec = '0;
    for (int c = 0; c < 8; c++) begin
      vec[c] = exec_mode | running;
      cyc();
    end
    check_eq("post_rst_idle", 32'(vec), 0);
    check_eq("post_rst_count", 32'(exec_count), 0);
    cpu_pc = 4'd2; #1;
    check_eq("post_rst_mem2", {24'd0, opcode, immediate}, 32'h2D);
    cpu_pc = 4'd1; #1;
    check_eq("post_rst_mem1", {24'd0, opcode, immediate}, 32'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
